// File: rtl/alu_share_ctrl_pkg.sv
// alu_share_ctrl_pkg: shared op encodings, FSM states and 7-segment patterns for alu_share_ctrl
package alu_share_ctrl_pkg;
  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_OR  = 2'b01;
  localparam logic [1:0] OP_SUB = 2'b10;
  localparam logic [1:0] OP_XOR = 2'b11;
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_e;
  localparam logic [6:0] SEG_PAT [16] = '{
    7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
    7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
    7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
    7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
  };
endpackage

// File: rtl/alu_share_ctrl_alu_core.sv
// alu_core: combinational W-bit add/or/sub/xor, results wrap mod 2^W
module alu_core import alu_share_ctrl_pkg::*; #(
  parameter int W = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [1:0]   op,
  output logic [W-1:0] out
);
  always_comb begin
    out = op == OP_ADD ? a + b :
          op == OP_OR  ? a | b :
          op == OP_SUB ? a - b : a ^ b;
  end
endmodule

// File: rtl/alu_share_ctrl.sv
// alu_share_ctrl: round-robin sharing of one ALU among N_REQ requesters; seg display under ALU_SEG_DISP_EN
module alu_share_ctrl import alu_share_ctrl_pkg::*; #(
  parameter int N_REQ = 4,
  parameter int W     = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [N_REQ-1:0]           req_valid,
  input  logic [N_REQ*W-1:0]         req_a,
  input  logic [N_REQ*W-1:0]         req_b,
  input  logic [N_REQ*2-1:0]         req_op,
  output logic [N_REQ-1:0]           req_ready,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [$clog2(N_REQ)-1:0]   rsp_id,
  output logic [W-1:0]               rsp_out,
  output logic [6:0]                 seg
);
  localparam int IW = $clog2(N_REQ);
  state_e state_q, state_d;
  logic [IW-1:0] rr_ptr_q, rr_ptr_d, grant, rsp_id_q, rsp_id_d;
  logic [W-1:0] a_q, a_d, b_q, b_d, rsp_out_q, rsp_out_d, alu_out;
  logic [1:0] op_q, op_d;
  logic rsp_valid_q, rsp_valid_d, take;
  always_comb begin
    int s;
    s = 0;
    grant = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      s = int'(rr_ptr_q) + k;
      s = s >= N_REQ ? s - N_REQ : s;
      grant = req_valid[s] ? IW'(s) : grant;
    end
  end
  assign take = state_q == IDLE && |req_valid;
  assign req_ready = (rst_n && take) ? N_REQ'(1) << grant : '0;
  alu_core #(.W(W)) u_alu (.a(a_q), .b(b_q), .op(op_q), .out(alu_out));
  always_comb begin
    state_d = state_q == IDLE ? (take ? EXEC : IDLE) :
              state_q == EXEC ? RESP : (rsp_ready ? IDLE : RESP);
    rr_ptr_d = take ? (grant == IW'(N_REQ - 1) ? '0 : grant + 1'b1) : rr_ptr_q;
    a_d = take ? req_a[int'(grant)*W +: W] : a_q;
    b_d = take ? req_b[int'(grant)*W +: W] : b_q;
    op_d = take ? req_op[int'(grant)*2 +: 2] : op_q;
    rsp_id_d = take ? grant : rsp_id_q;
    rsp_out_d = state_q == EXEC ? alu_out : rsp_out_q;
    rsp_valid_d = state_q == EXEC ? 1'b1 : (rsp_ready ? 1'b0 : rsp_valid_q);
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rr_ptr_q <= '0;
      a_q <= '0;
      b_q <= '0;
      op_q <= '0;
      rsp_id_q <= '0;
      rsp_out_q <= '0;
      rsp_valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_ptr_q <= rr_ptr_d;
      a_q <= a_d;
      b_q <= b_d;
      op_q <= op_d;
      rsp_id_q <= rsp_id_d;
      rsp_out_q <= rsp_out_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end
  assign rsp_valid = rsp_valid_q;
  assign rsp_id = rsp_id_q;
  assign rsp_out = rsp_out_q;
`ifdef ALU_SEG_DISP_EN
  logic [6:0] seg_q, seg_d;
  always_comb begin
    seg_d = (rsp_valid_q && rsp_ready) ? SEG_PAT[rsp_out_q[3:0]] : seg_q;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) seg_q <= '0;
    else seg_q <= seg_d;
  end
  assign seg = seg_q;
`else
  assign seg = 7'b0000000;
`endif
endmodule
